// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scanner: glyph table (active-high g..a),
// segment bit positions and a width helper for counters.
package seg_pkg;

  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Active-high g..a patterns for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Register-write and display-pin bundle for seg_scan_mux.
interface seg_scan_mux_if #(
  parameter int DIGITS = 8
);
  logic                  cs;
  logic [4*DIGITS-1:0]   i_data;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     i_blink;
  logic                  i_lzb;
  logic [3:0]            i_bright;
  logic [7:0]            o_seg;
  logic [DIGITS-1:0]     o_sel;
  logic                  o_frame;

  modport master (
    output cs, i_data, i_dp, i_blink, i_lzb, i_bright,
    input  o_seg, o_sel, o_frame
  );

  modport slave (
    input  cs, i_data, i_dp, i_blink, i_lzb, i_bright,
    output o_seg, o_sel, o_frame
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder producing an active-high
// {dp,g,f,e,d,c,b,a} vector with glyph blanking and full blanking.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank_glyph,
  input  logic       blank_all,
  output logic [7:0] seg
);

  // Glyph lookup; leading-zero blanking keeps dp, blink blanking kills everything.
  always_comb begin
    seg = SEG_OFF;
    if (!blank_all) begin
      if (!blank_glyph) seg[6:0] = GLYPH[nib];
      seg[SEG_DP] = dp;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed hex display scanner: staging/active register pair for tear-free
// updates, slot/digit scan counters, frame-based blink and PWM select gating.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 32768,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  seg_scan_mux_if.slave  bus
);

  localparam int SLOT_W = clog2(SCAN_DIV);
  localparam int IDX_W  = clog2(DIGITS);
  localparam int BLK_W  = clog2(BLINK_FRAMES + 1);
  localparam logic [7:0]        SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? '1 : '0;

  logic [SLOT_W-1:0]   slot_cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [BLK_W-1:0]    blink_cnt_reg;
  logic                blink_on_reg;
  logic                loaded_reg;

  logic [4*DIGITS-1:0] stg_data_reg, act_data_reg;
  logic [DIGITS-1:0]   stg_dp_reg, act_dp_reg;
  logic [DIGITS-1:0]   stg_blink_reg, act_blink_reg;
  logic                stg_lzb_reg, act_lzb_reg;
  logic [3:0]          stg_bright_reg, act_bright_reg;

  logic [7:0]          o_seg_reg;
  logic [DIGITS-1:0]   o_sel_reg;
  logic                o_frame_reg;

  logic slot_last, wrap;
  assign slot_last = (slot_cnt_reg == SLOT_W'(SCAN_DIV - 1));
  assign wrap      = slot_last && (idx_reg == IDX_W'(DIGITS - 1));

  // Slot counter and digit index; the index advances on the last slot cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      slot_cnt_reg <= slot_last ? '0 : slot_cnt_reg + 1'b1;
      if (slot_last) idx_reg <= wrap ? '0 : idx_reg + 1'b1;
    end
  end

  // Frame counter for blink; phase toggles every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= !blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // Staging captures every write; active follows staging only at frame wrap,
  // except the first write after reset which lands immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loaded_reg     <= 1'b0;
      stg_data_reg   <= '0;
      stg_dp_reg     <= '0;
      stg_blink_reg  <= '0;
      stg_lzb_reg    <= 1'b0;
      stg_bright_reg <= '0;
      act_data_reg   <= '0;
      act_dp_reg     <= '0;
      act_blink_reg  <= '0;
      act_lzb_reg    <= 1'b0;
      act_bright_reg <= '0;
    end else begin
      if (bus.cs) begin
        stg_data_reg   <= bus.i_data;
        stg_dp_reg     <= bus.i_dp;
        stg_blink_reg  <= bus.i_blink;
        stg_lzb_reg    <= bus.i_lzb;
        stg_bright_reg <= bus.i_bright;
      end
      if (bus.cs && !loaded_reg) begin
        loaded_reg     <= 1'b1;
        act_data_reg   <= bus.i_data;
        act_dp_reg     <= bus.i_dp;
        act_blink_reg  <= bus.i_blink;
        act_lzb_reg    <= bus.i_lzb;
        act_bright_reg <= bus.i_bright;
      end else if (wrap) begin
        act_data_reg   <= stg_data_reg;
        act_dp_reg     <= stg_dp_reg;
        act_blink_reg  <= stg_blink_reg;
        act_lzb_reg    <= stg_lzb_reg;
        act_bright_reg <= stg_bright_reg;
      end
    end
  end

  // Leading-zero flags: a digit is blanked when it and all higher nibbles are 0.
  logic [DIGITS-1:0] lz_vec;
  logic [DIGITS-1:0] sel_hi;
  logic              sel_gate;

  assign sel_gate = (slot_cnt_reg != '0) &&
                    (slot_cnt_reg[SLOT_W-1 -: 4] <= act_bright_reg);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign lz_vec[gi] = 1'b0;
      end else begin : g_upper
        assign lz_vec[gi] = act_lzb_reg && (act_data_reg[4*DIGITS-1:4*gi] == '0);
      end
      assign sel_hi[gi] = sel_gate && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  logic [7:0] seg_hi;

  seg_hex_decode u_decode (
    .nib         (act_data_reg[{idx_reg, 2'b00} +: 4]),
    .dp          (act_dp_reg[idx_reg]),
    .blank_glyph (lz_vec[idx_reg]),
    .blank_all   (act_blink_reg[idx_reg] && !blink_on_reg),
    .seg         (seg_hi)
  );

  // Output register: applies pin polarity and marks the cycle the index wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_seg_reg   <= SEG_IDLE;
      o_sel_reg   <= SEL_IDLE;
      o_frame_reg <= 1'b0;
    end else begin
      o_seg_reg   <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      o_sel_reg   <= SEL_ACTIVE_LOW ? ~sel_hi : sel_hi;
      o_frame_reg <= wrap;
    end
  end

  assign bus.o_seg   = o_seg_reg;
  assign bus.o_sel   = o_sel_reg;
  assign bus.o_frame = o_frame_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 32-cycle slots, 2-frame blink, active-low
// pins). Expected pins come from a model that derives slot, digit and frame
// from the cycle count since reset.
module tb_seg_scan_mux;

  localparam int D     = 4;
  localparam int SD    = 32;
  localparam int BF    = 2;
  localparam int FRAME = SD * D;

  logic clk;
  logic reset_n;

  seg_scan_mux_if #(.DIGITS(D)) bus ();

  seg_scan_mux #(
    .DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Active-low glyphs, dp off.
  logic [7:0] glyph_al [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference model state
  int          n;
  logic        m_loaded;
  logic [15:0] m_stg_data, m_act_data;
  logic [3:0]  m_stg_dp, m_act_dp, m_stg_blink, m_act_blink;
  logic        m_stg_lzb, m_act_lzb;
  logic [3:0]  m_stg_bright, m_act_bright;

  // Current input drive
  logic [15:0] c_data;
  logic [3:0]  c_dp, c_blink, c_bright;
  logic        c_lzb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_loaded = 1'b0;
    m_stg_data = '0; m_act_data = '0;
    m_stg_dp = '0; m_act_dp = '0;
    m_stg_blink = '0; m_act_blink = '0;
    m_stg_lzb = 1'b0; m_act_lzb = 1'b0;
    m_stg_bright = '0; m_act_bright = '0;
  endtask

  function automatic logic [7:0] exp_seg(input int k);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [7:0]  s;
    int          frame;
    upper = m_act_data >> (4 * k);
    nib   = upper[3:0];
    frame = n / FRAME;
    if (m_act_blink[k] && ((frame / BF) % 2 == 1)) return 8'hFF;
    if (m_act_lzb && k > 0 && upper == 16'h0) s = 8'hFF;
    else s = glyph_al[nib];
    if (m_act_dp[k]) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [3:0] exp_sel();
    int slot, dig;
    slot = n % SD;
    dig  = (n / SD) % D;
    if (slot != 0 && (slot / (SD / 16)) <= int'(m_act_bright))
      return 4'hF & ~(4'b0001 << dig);
    return 4'hF;
  endfunction

  // One clock: drive inputs, predict pins from pre-edge state, check after edge.
  task automatic step(input logic c);
    logic [7:0] es;
    logic [3:0] esel;
    logic       ef, wrap;
    bus.cs = c; bus.i_data = c_data; bus.i_dp = c_dp; bus.i_blink = c_blink;
    bus.i_lzb = c_lzb; bus.i_bright = c_bright;
    es   = exp_seg((n / SD) % D);
    esel = exp_sel();
    wrap = ((n + 1) % FRAME) == 0;
    ef   = wrap;
    if (c && !m_loaded) begin
      m_loaded = 1'b1;
      m_act_data = c_data; m_act_dp = c_dp; m_act_blink = c_blink;
      m_act_lzb = c_lzb; m_act_bright = c_bright;
    end else if (wrap) begin
      m_act_data = m_stg_data; m_act_dp = m_stg_dp; m_act_blink = m_stg_blink;
      m_act_lzb = m_stg_lzb; m_act_bright = m_stg_bright;
    end
    if (c) begin
      m_stg_data = c_data; m_stg_dp = c_dp; m_stg_blink = c_blink;
      m_stg_lzb = c_lzb; m_stg_bright = c_bright;
    end
    @(posedge clk);
    n++;
    @(negedge clk);
    bus.cs = 1'b0;
    check("o_seg", 32'(bus.o_seg), 32'(es));
    check("o_sel", 32'(bus.o_sel), 32'(esel));
    check("o_frame", 32'(bus.o_frame), 32'(ef));
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bl, input logic lz, input logic [3:0] br);
    c_data = d; c_dp = dp; c_blink = bl; c_lzb = lz; c_bright = br;
    $display("write cycle=%0d pos=%0d data=%h dp=%b blink=%b lzb=%b bright=%0d",
             n, n % FRAME, d, dp, bl, lz, br);
    step(1'b1);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0);
  endtask

  // Advance until the frame position equals pos (bounded by one frame).
  task automatic idle_to(input int pos);
    for (int i = 0; i < FRAME && (n % FRAME) != pos; i++) step(1'b0);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_seg"}, 32'(bus.o_seg), 32'h0FF);
    check({tag, "_sel"}, 32'(bus.o_sel), 32'hF);
    check({tag, "_frame"}, 32'(bus.o_frame), 32'h0);
  endtask

  initial begin
    bus.cs = 1'b0; bus.i_data = '0; bus.i_dp = '0; bus.i_blink = '0;
    bus.i_lzb = 1'b0; bus.i_bright = '0;
    c_data = '0; c_dp = '0; c_blink = '0; c_lzb = 1'b0; c_bright = '0;
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_pins("reset");
    reset_n = 1'b1;

    // Plain glyphs at full brightness
    write(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'hF);
    idle(3 * FRAME);
    // Leading-zero blanking with a dp on a blanked digit
    write(16'h0005, 4'b0100, 4'b0000, 1'b1, 4'hF);
    idle(2 * FRAME);
    // All-zero value: only digit 0 shows
    write(16'h0000, 4'b0000, 4'b0000, 1'b1, 4'hF);
    idle(2 * FRAME);
    // Blink on digit 0
    write(16'h12AF, 4'b0001, 4'b0001, 1'b0, 4'hF);
    idle(5 * FRAME);
    // Minimum brightness
    write(16'h12AF, 4'b0000, 4'b0000, 1'b0, 4'h0);
    idle(2 * FRAME);
    // Mid-frame write, then a write exactly on the wrap edge
    idle_to(40);
    write(16'h1111, 4'b0000, 4'b0000, 1'b0, 4'hF);
    idle_to(FRAME - 1);
    write(16'h2222, 4'b0000, 4'b0000, 1'b0, 4'hF);
    idle(3 * FRAME);

    // Reset in the middle of a frame, then first write loads immediately
    idle_to(70);
    reset_n = 1'b0;
    #1;
    check_reset_pins("midreset");
    @(negedge clk);
    check_reset_pins("midreset_hold");
    model_reset();
    reset_n = 1'b1;
    idle(50);
    write(16'hBEEF, 4'b1010, 4'b0000, 1'b1, 4'h7);
    idle(2 * FRAME);

    // Randomized writes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2)
        write(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      else
        step(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised multiplexed 7-segment scanner for a DIGITS-wide hex display; next generation of the team's 8-digit scanner.
- Adds a configurable digit count, scan rate and output polarity.
- Adds per-digit decimal points, leading-zero blanking and per-digit blink.
- Adds 16-level PWM brightness with an anti-ghosting guard cycle, and frame-synchronous (tear-free) data update.
- Sits between the CPU/game-logic register write path (cs strobe) and the board's segment/select pins.

Parameters:
- DIGITS, 8, number of digits scanned (2..16).
- SCAN_DIV, 32768, clocks per digit slot; power of two, >= 32.
- BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1).
- SEG_ACTIVE_LOW, 1, 1 = segment pins active-low, 0 = active-high.
- SEL_ACTIVE_LOW, 1, 1 = digit selects active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  write strobe; captures all i_* inputs into the staging registers.
- i_data  in  4*DIGITS  hex nibbles; nibble k drives digit k (digit 0 = rightmost).
- i_dp  in  DIGITS  decimal-point enable per digit.
- i_blink  in  DIGITS  blink enable per digit.
- i_lzb  in  1  leading-zero blanking enable.
- i_bright  in  4  brightness, 0 = 1/16 duty, 15 = full duty.
- o_seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- o_sel  out  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW.
- o_frame  out  1  one-cycle pulse when digit index wraps DIGITS-1 -> 0.

Behaviour:
- Reset (async, reset_n=0):
  - staging and active registers cleared to 0; slot counter, digit index and blink counter cleared to 0; blink phase = on.
  - o_seg = all segments off (8'hFF when active-low); o_sel = no digit selected (all 1s when active-low); o_frame = 0.
- Staging: cs=1 at a clock edge latches i_data, i_dp, i_blink, i_lzb and i_bright into the staging registers. A later cs overwrites them (last write wins).
- Active registers are copied from staging only in the cycle the digit index wraps to 0, so no frame ever shows mixed old and new data.
  - Exception: the first cs after reset also loads the active registers directly, so the display is valid within one frame.
- Slot counter: counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the digit index increments; index DIGITS-1 wraps to 0.
  - o_frame is asserted for exactly the cycle in which the index becomes 0.
- Blink counter: counts frames 0..BLINK_FRAMES-1. On wrap, the blink phase toggles.
- Per-digit pipeline, registered, 1-cycle latency from index/slot change to pins. For digit k:
  - nib = active_data[4k+3:4k].
  - Leading zero: i_lzb=1, k>0, and nib and every higher nibble are 0. Digit 0 is never blanked.
  - Segment bits g..a: the hex glyph for nib; all off if the digit is a leading zero.
  - dp bit: active_dp[k]; dp is not suppressed by leading-zero blanking.
  - Blink: if active_blink[k]=1 and blink phase = off, every bit including dp is off.
- Select gating: o_sel is active for digit k only when both hold:
  - slot_cnt != 0 (one-cycle guard at every slot start; o_seg still updates in that cycle);
  - slot_cnt[top 4 bits] <= bright.
  - Otherwise o_sel shows no digit selected. A bright=15 digit is therefore lit for SCAN_DIV-1 of SCAN_DIV cycles.
- Polarity: segment and select values are computed active-high internally and inverted at the output register per the polarity parameters.
- Simultaneous events:
  - cs in the wrap cycle: active registers take the OLD staging contents; the new write lands in staging and applies at the next wrap.
  - reset_n deasserted mid-frame: scanning resumes from digit 0 and slot 0.
- Hex glyphs (active-low, dp off):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E

Decomposition:
- Package seg_pkg holds:
  - the 16-entry glyph constant array (active-high g..a);
  - SEG_DP bit index = 7 and SEG_OFF constant;
  - function clog2 for the slot and index counter widths.
- One sub-module, seg_hex_decode: combinational nibble + dp + blank inputs -> 8-bit active-high segment vector.
- Scanner, staging, PWM and blink logic stay in seg_scan_mux.

Test Plan (DIGITS=4, SCAN_DIV=32, BLINK_FRAMES=2, both polarities active-low):
- Reset then cs with i_data=16'h12AF, dp=0, bright=15 -> o_sel cycles 1110,1101,1011,0111; o_seg = F9? no: digit0 8E, digit1 88, digit2 A4, digit3 F9; o_frame pulses every 128 cycles.
- i_data=16'h0005, i_lzb=1, i_dp=4'b0100 -> digit0 92; digit1 FF; digit2 7F (dp only); digit3 FF.
- i_data=16'h0000, i_lzb=1 -> digit0 C0; digits 1-3 FF.
- i_blink=4'b0001 -> digit0 shows its glyph for 2 frames, then FF for 2 frames, repeating; other digits unaffected.
- i_bright=0 -> each selected digit is active for slot_cnt 1 only; o_sel is all 1s at slot_cnt 0 and at slot_cnt >= 2.
- cs with 16'h1111 mid-frame, then cs with 16'h2222 exactly in the wrap cycle -> next frame shows 1111, the following frame shows 2222; no frame mixes the two values.
